// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates entries at the tail, captures FU writebacks by index,
// and retires completed entries from the head into the register file commit port.
module rob_commit #(
    parameter int ROB_DEPTH    = 8,
    parameter int ROB_IDX_SIZE = 3,
    parameter int GPR_SIZE     = 64,
    parameter int GPR_IDX_SIZE = 5
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic                    in_flush,
    input  logic                    in_alloc_valid,
    input  logic [GPR_IDX_SIZE-1:0] in_alloc_dst,
    input  logic                    in_alloc_set_nzcv,
    output logic                    out_alloc_ready,
    output logic [ROB_IDX_SIZE-1:0] out_next_rob_index,
    input  logic                    in_wb_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_wb_rob_index,
    input  logic [GPR_SIZE-1:0]     in_wb_value,
    input  logic [3:0]              in_wb_nzcv,
    output logic                    out_commit,
    output logic [GPR_SIZE-1:0]     out_commit_value,
    output logic [GPR_IDX_SIZE-1:0] out_commit_reg_index,
    output logic [ROB_IDX_SIZE-1:0] out_commit_rob_index,
    output logic                    out_commit_set_nzcv,
    output logic [3:0]              out_commit_nzcv,
    output logic [ROB_IDX_SIZE:0]   out_count,
    output logic                    out_empty
);

    localparam logic [ROB_IDX_SIZE:0] FULL_COUNT = (ROB_IDX_SIZE + 1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0]    valid;
    logic [ROB_DEPTH-1:0]    done;
    logic [ROB_DEPTH-1:0]    set_nzcv_bits;
    logic [GPR_IDX_SIZE-1:0] dst_mem   [ROB_DEPTH];
    logic [GPR_SIZE-1:0]     value_mem [ROB_DEPTH];
    logic [3:0]              nzcv_mem  [ROB_DEPTH];

    logic [ROB_IDX_SIZE-1:0] head;
    logic [ROB_IDX_SIZE-1:0] tail;
    logic [ROB_IDX_SIZE:0]   count;

    logic alloc_fire;
    logic wb_fire;
    logic retire;

    // Every decision uses registered state only, so no input reaches an output combinationally.
    assign out_alloc_ready    = (count != FULL_COUNT);
    assign out_empty          = (count == '0);
    assign out_count          = count;
    assign out_next_rob_index = tail;

    assign alloc_fire = in_alloc_valid && out_alloc_ready;
    assign wb_fire    = in_wb_valid && valid[in_wb_rob_index];
    assign retire     = valid[head] && done[head];

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            valid                <= '0;
            done                 <= '0;
            out_commit           <= 1'b0;
            out_commit_value     <= '0;
            out_commit_reg_index <= '0;
            out_commit_rob_index <= '0;
            out_commit_set_nzcv  <= 1'b0;
            out_commit_nzcv      <= '0;
        end else if (in_flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            valid      <= '0;
            done       <= '0;
            out_commit <= 1'b0;
        end else begin
            out_commit <= retire;
            // The tail slot is never valid while not full, so allocate and writeback never collide.
            if (alloc_fire) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                tail        <= tail + ROB_IDX_SIZE'(1);
            end
            if (wb_fire) begin
                done[in_wb_rob_index] <= 1'b1;
            end
            if (retire) begin
                valid[head]          <= 1'b0;
                head                 <= head + ROB_IDX_SIZE'(1);
                out_commit_value     <= value_mem[head];
                out_commit_reg_index <= dst_mem[head];
                out_commit_rob_index <= head;
                out_commit_set_nzcv  <= set_nzcv_bits[head];
                out_commit_nzcv      <= nzcv_mem[head];
            end
            case ({alloc_fire, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; the valid/done bits gate every use of it.
    always_ff @(posedge in_clk) begin
        if (alloc_fire) begin
            dst_mem[tail]       <= in_alloc_dst;
            set_nzcv_bits[tail] <= in_alloc_set_nzcv;
        end
        if (wb_fire) begin
            value_mem[in_wb_rob_index] <= in_wb_value;
            nzcv_mem[in_wb_rob_index]  <= in_wb_nzcv;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic, all checked every cycle
// against a program-order queue model of the reorder buffer.
module tb_rob_commit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_dst = '0;
    logic        alloc_set_nzcv = 1'b0;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_idx = '0;
    logic [63:0] wb_value = '0;
    logic [3:0]  wb_nzcv = '0;

    logic        alloc_ready;
    logic [2:0]  next_rob_index;
    logic        commit;
    logic [63:0] commit_value;
    logic [4:0]  commit_reg_index;
    logic [2:0]  commit_rob_index;
    logic        commit_set_nzcv;
    logic [3:0]  commit_nzcv;
    logic [3:0]  count;
    logic        empty;

    int total = 0;
    int bad = 0;

    rob_commit #(
        .ROB_DEPTH(8), .ROB_IDX_SIZE(3), .GPR_SIZE(64), .GPR_IDX_SIZE(5)
    ) dut (
        .in_clk(clk),
        .in_rst_n(rst_n),
        .in_flush(flush),
        .in_alloc_valid(alloc_valid),
        .in_alloc_dst(alloc_dst),
        .in_alloc_set_nzcv(alloc_set_nzcv),
        .out_alloc_ready(alloc_ready),
        .out_next_rob_index(next_rob_index),
        .in_wb_valid(wb_valid),
        .in_wb_rob_index(wb_idx),
        .in_wb_value(wb_value),
        .in_wb_nzcv(wb_nzcv),
        .out_commit(commit),
        .out_commit_value(commit_value),
        .out_commit_reg_index(commit_reg_index),
        .out_commit_rob_index(commit_rob_index),
        .out_commit_set_nzcv(commit_set_nzcv),
        .out_commit_nzcv(commit_nzcv),
        .out_count(count),
        .out_empty(empty)
    );

    always #5 clk = ~clk;

    // Model: instructions in program order; the front is the oldest.
    typedef struct packed {
        logic [2:0]  idx;
        logic [4:0]  dst;
        logic        sn;
        logic        done;
        logic [63:0] value;
        logic [3:0]  nzcv;
    } rec_t;

    rec_t        q[$];
    int          m_tail = 0;
    logic        e_commit = 1'b0;
    logic [63:0] e_value = '0;
    logic [4:0]  e_reg = '0;
    logic [2:0]  e_rob = '0;
    logic        e_sn = 1'b0;
    logic [3:0]  e_nzcv = '0;
    logic        do_retire;
    logic        do_alloc;
    rec_t        new_rec;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_tail   = 0;
            e_commit = 1'b0;
            e_value  = '0;
            e_reg    = '0;
            e_rob    = '0;
            e_sn     = 1'b0;
            e_nzcv   = '0;
        end else if (flush) begin
            q.delete();
            m_tail   = 0;
            e_commit = 1'b0;
        end else begin
            do_retire = (q.size() > 0) && q[0].done;
            do_alloc  = alloc_valid && (q.size() < DEPTH);
            e_commit  = do_retire;
            if (do_retire) begin
                e_value = q[0].value;
                e_reg   = q[0].dst;
                e_rob   = q[0].idx;
                e_sn    = q[0].sn;
                e_nzcv  = q[0].nzcv;
                q.delete(0);
            end
            if (wb_valid) begin
                foreach (q[i]) begin
                    if (q[i].idx == wb_idx) begin
                        q[i].done  = 1'b1;
                        q[i].value = wb_value;
                        q[i].nzcv  = wb_nzcv;
                    end
                end
            end
            if (do_alloc) begin
                new_rec       = '0;
                new_rec.idx   = 3'(m_tail);
                new_rec.dst   = alloc_dst;
                new_rec.sn    = alloc_set_nzcv;
                q.push_back(new_rec);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        check_output("commit", 64'(commit), 64'(e_commit));
        check_output("count", 64'(count), 64'(q.size()));
        check_output("next_idx", 64'(next_rob_index), 64'(m_tail));
        check_output("ready", 64'(alloc_ready), 64'(q.size() < DEPTH));
        check_output("empty", 64'(empty), 64'(q.size() == 0));
        if (e_commit) begin
            check_output("c_value", commit_value, e_value);
            check_output("c_reg", 64'(commit_reg_index), 64'(e_reg));
            check_output("c_rob", 64'(commit_rob_index), 64'(e_rob));
            check_output("c_sn", 64'(commit_set_nzcv), 64'(e_sn));
            check_output("c_nzcv", 64'(commit_nzcv), 64'(e_nzcv));
        end
    end

    task automatic apply_stimulus(input logic av, input logic [4:0] dst, input logic sn,
                                  input logic wv, input logic [2:0] widx, input logic [63:0] wval,
                                  input logic [3:0] wnz, input logic fl);
        alloc_valid    = av;
        alloc_dst      = dst;
        alloc_set_nzcv = sn;
        wb_valid       = wv;
        wb_idx         = widx;
        wb_value       = wval;
        wb_nzcv        = wnz;
        flush          = fl;
        @(negedge clk);
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 64'd0, 4'd0, 1'b0);
    endtask

    task automatic alloc(input logic [4:0] dst, input logic sn);
        apply_stimulus(1'b1, dst, sn, 1'b0, 3'd0, 64'd0, 4'd0, 1'b0);
    endtask

    task automatic wb(input logic [2:0] idx, input logic [63:0] val, input logic [3:0] nz);
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1, idx, val, nz, 1'b0);
    endtask

    task automatic do_flush();
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 64'd0, 4'd0, 1'b1);
    endtask

    task automatic check_reset_values();
        check_output("rst_commit", 64'(commit), 64'd0);
        check_output("rst_value", commit_value, 64'd0);
        check_output("rst_reg", 64'(commit_reg_index), 64'd0);
        check_output("rst_rob", 64'(commit_rob_index), 64'd0);
        check_output("rst_sn", 64'(commit_set_nzcv), 64'd0);
        check_output("rst_nzcv", 64'(commit_nzcv), 64'd0);
        check_output("rst_ready", 64'(alloc_ready), 64'd1);
        check_output("rst_next", 64'(next_rob_index), 64'd0);
        check_output("rst_count", 64'(count), 64'd0);
        check_output("rst_empty", 64'(empty), 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Basic allocate and single retire.
        alloc(5'd1, 1'b0);
        check_output("t1_next1", 64'(next_rob_index), 64'd1);
        alloc(5'd2, 1'b0);
        check_output("t1_next2", 64'(next_rob_index), 64'd2);
        alloc(5'd3, 1'b0);
        check_output("t1_next3", 64'(next_rob_index), 64'd3);
        check_output("t1_count3", 64'(count), 64'd3);
        wb(3'd0, 64'd5, 4'd0);
        check_output("t1_no_early", 64'(commit), 64'd0);
        idle();
        check_output("t1_commit", 64'(commit), 64'd1);
        check_output("t1_value", commit_value, 64'd5);
        check_output("t1_reg", 64'(commit_reg_index), 64'd1);
        check_output("t1_rob", 64'(commit_rob_index), 64'd0);
        idle();
        check_output("t1_single", 64'(commit), 64'd0);
        check_output("t1_count2", 64'(count), 64'd2);

        // Out-of-order completion retires in order on consecutive cycles.
        do_flush();
        alloc(5'd10, 1'b0);
        alloc(5'd11, 1'b0);
        alloc(5'd12, 1'b0);
        wb(3'd2, 64'd30, 4'd0);
        wb(3'd1, 64'd20, 4'd0);
        check_output("t2_wait", 64'(commit), 64'd0);
        wb(3'd0, 64'd10, 4'd0);
        check_output("t2_wait0", 64'(commit), 64'd0);
        idle();
        check_output("t2_c10", commit_value, 64'd10);
        idle();
        check_output("t2_c20", commit_value, 64'd20);
        check_output("t2_pulse2", 64'(commit), 64'd1);
        idle();
        check_output("t2_c30", commit_value, 64'd30);
        check_output("t2_reg", 64'(commit_reg_index), 64'd12);
        idle();
        check_output("t2_end", 64'(commit), 64'd0);
        check_output("t2_empty", 64'(empty), 64'd1);

        // Fill, drop, retire-while-full, wrap.
        do_flush();
        for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1), 1'b0);
        check_output("t3_notready", 64'(alloc_ready), 64'd0);
        check_output("t3_count8", 64'(count), 64'd8);
        alloc(5'd31, 1'b0);
        check_output("t3_dropped", 64'(count), 64'd8);
        check_output("t3_next0", 64'(next_rob_index), 64'd0);
        apply_stimulus(1'b1, 5'd30, 1'b0, 1'b1, 3'd0, 64'd7, 4'd0, 1'b0);
        check_output("t3_still_full", 64'(count), 64'd8);
        alloc(5'd30, 1'b0);
        check_output("t3_commit", 64'(commit), 64'd1);
        check_output("t3_value", commit_value, 64'd7);
        check_output("t3_count7", 64'(count), 64'd7);
        check_output("t3_ready", 64'(alloc_ready), 64'd1);
        check_output("t3_wrapidx", 64'(next_rob_index), 64'd0);
        alloc(5'd30, 1'b0);
        check_output("t3_refill", 64'(count), 64'd8);
        check_output("t3_next1", 64'(next_rob_index), 64'd1);

        // NZCV and writeback to an unallocated slot.
        do_flush();
        alloc(5'd4, 1'b1);
        wb(3'd0, 64'h99, 4'b0100);
        idle();
        check_output("t4_commit", 64'(commit), 64'd1);
        check_output("t4_sn", 64'(commit_set_nzcv), 64'd1);
        check_output("t4_nzcv", 64'(commit_nzcv), 64'b0100);
        check_output("t4_reg", 64'(commit_reg_index), 64'd4);
        wb(3'd5, 64'h55, 4'b1111);
        idle();
        check_output("t4_ignored", 64'(commit), 64'd0);
        check_output("t4_count0", 64'(count), 64'd0);

        // Flush beats a retire that would otherwise fire.
        do_flush();
        for (int i = 0; i < 4; i++) alloc(5'(i + 2), 1'b0);
        wb(3'd1, 64'd21, 4'd0);
        wb(3'd0, 64'd20, 4'd0);
        do_flush();
        check_output("t5_nocommit", 64'(commit), 64'd0);
        check_output("t5_count", 64'(count), 64'd0);
        check_output("t5_next", 64'(next_rob_index), 64'd0);
        check_output("t5_empty", 64'(empty), 64'd1);
        idle();
        check_output("t5_quiet", 64'(commit), 64'd0);

        // Asynchronous reset while a pulse is showing.
        alloc(5'd6, 1'b0);
        alloc(5'd7, 1'b0);
        wb(3'd0, 64'h11, 4'd1);
        wb(3'd1, 64'h22, 4'd2);
        check_output("t6_pulse", 64'(commit), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check_output("t6_nopulse", 64'(commit), 64'd0);
        idle();
        check_output("t6_nopulse2", 64'(commit), 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            apply_stimulus($urandom_range(0, 99) < 55, 5'($urandom), 1'($urandom),
                           $urandom_range(0, 99) < 50, 3'($urandom), {$urandom, $urandom},
                           4'($urandom), $urandom_range(0, 99) < 2);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
